// File: rtl/unified_mem_ctrl.sv
// rtl/unified_mem_ctrl.sv - byte-serialising arbiter for a shared unified memory
//
// Serialises one fetch or load/store request at a time into 1-4 little-endian
// byte cycles on a single-ported byte-wide memory. Read bytes are assembled
// into a word and returned with a one-cycle ready pulse.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   if_req, if_addr           fetch request, held with stable address until if_ready
//   if_ready, if_rdata        fetch completion pulse and fetched word
//   d_req, d_we, d_size,      data request: store/load, size (00 b, 01 h, 1x w),
//   d_addr, d_wdata           byte address and store data (low byte first)
//   d_ready, d_rdata          data completion pulse and zero-extended load data
//   m_addr, m_we, m_wdata     byte address, write enable and write byte to the array
//   m_rdata                   combinational read byte at m_addr
//   busy                      high whenever the sequencer is not idle

module unified_mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t      state;
  logic        last_grant_d;  // 1 = data port was granted last
  logic        gnt_d;         // current transfer belongs to the data port
  logic        we_r;
  logic [31:0] wdata_r;
  logic [31:0] result;
  logic [1:0]  cnt;
  logic [1:0]  last_cnt;      // n-1, index of the final byte

  logic        pick_d;
  logic [1:0]  d_last_cnt;
  logic [1:0]  next_cnt;
  logic [31:0] result_nxt;
  logic [7:0]  wbyte_nxt;

  // Data wins a tie unless it was the previous grantee, so the ports alternate.
  always_comb begin
    pick_d     = d_req && (!if_req || !last_grant_d);
    d_last_cnt = (d_size == 2'b00) ? 2'd0 :
                 (d_size == 2'b01) ? 2'd1 : 2'd3;
    next_cnt   = cnt + 2'd1;
    wbyte_nxt  = wdata_r[8*next_cnt +: 8];
    result_nxt = result;
    // The final byte is merged here so it can be returned on the same edge.
    if (!we_r) begin
      result_nxt[8*cnt +: 8] = m_rdata;
    end
  end

  // m_addr/m_we/m_wdata are registered and always describe the byte being
  // transferred in the current XFER cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      gnt_d        <= 1'b0;
      we_r         <= 1'b0;
      wdata_r      <= '0;
      result       <= '0;
      cnt          <= '0;
      last_cnt     <= '0;
      if_ready     <= 1'b0;
      d_ready      <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      m_addr       <= '0;
      m_we         <= 1'b0;
      m_wdata      <= '0;
      busy         <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            gnt_d    <= pick_d;
            we_r     <= pick_d && d_we;
            wdata_r  <= pick_d ? d_wdata : 32'h0;
            last_cnt <= pick_d ? d_last_cnt : 2'd3;
            cnt      <= 2'd0;
            result   <= '0;
            m_addr   <= pick_d ? d_addr : if_addr;
            m_we     <= pick_d && d_we;
            m_wdata  <= pick_d ? d_wdata[7:0] : 8'h00;
            busy     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          result <= result_nxt;
          if (cnt == last_cnt) begin
            m_we <= 1'b0;
            if (gnt_d) begin
              d_rdata <= result_nxt;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= result_nxt;
              if_ready <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt     <= next_cnt;
            m_addr  <= m_addr + 1'b1;  // wraps at the top of memory
            m_wdata <= wbyte_nxt;
          end
        end
        RESP: begin
          last_grant_d <= gnt_d;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
